// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: Tuse/Tnew hazard detection plus MD unit busy tracking.
// Optional macro STALL_PERF_CNT_EN adds a saturating stall-cycle counter (STALL_CYCLES) with clear input PERF_CLR.
module pipeline_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [4:0] D_RS_ADDR,
  input  logic [4:0] D_RT_ADDR,
  input  logic [1:0] D_TUSE_RS,
  input  logic [1:0] D_TUSE_RT,
  input  logic       D_IS_MD,
  input  logic [4:0] E_WADDR,
  input  logic [1:0] E_TNEW,
  input  logic [4:0] M_WADDR,
  input  logic [1:0] M_TNEW,
  input  logic       E_MD_START,
  input  logic       E_MD_TYPE,
`ifdef STALL_PERF_CNT_EN
  input  logic        PERF_CLR,
  output logic [31:0] STALL_CYCLES,
`endif
  output logic       STALL_PC,
  output logic       STALL_D,
  output logic       CLEAR_E,
  output logic       MD_BUSY
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] md_cnt;
  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;
  logic             stall;

  always_ff @(posedge clk) begin
    if (RESET)
      md_cnt <= '0;
    else if (E_MD_START)
      md_cnt <= E_MD_TYPE ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  // An operand stalls when it is read earlier (Tuse) than its producer can forward it (Tnew); $0 is never a hazard.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (D_TUSE_RS != 2'b11 && D_RS_ADDR != 5'd0)
      stall_rs = (D_RS_ADDR == E_WADDR && D_TUSE_RS < E_TNEW) ||
                 (D_RS_ADDR == M_WADDR && D_TUSE_RS < M_TNEW);
    if (D_TUSE_RT != 2'b11 && D_RT_ADDR != 5'd0)
      stall_rt = (D_RT_ADDR == E_WADDR && D_TUSE_RT < E_TNEW) ||
                 (D_RT_ADDR == M_WADDR && D_TUSE_RT < M_TNEW);
  end

  always_comb begin
    MD_BUSY  = !RESET && (md_cnt != '0);
    stall_md = D_IS_MD && (MD_BUSY || E_MD_START);
    stall    = !RESET && (stall_rs || stall_rt || stall_md);
    STALL_PC = stall;
    STALL_D  = stall;
    CLEAR_E  = stall;
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  // A clear wins over a coincident stall so the counter reads zero afterwards.
  always_ff @(posedge clk) begin
    if (RESET || PERF_CLR)
      stall_cycles_q <= '0;
    else if (stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign STALL_CYCLES = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed test-plan steps followed by randomized traffic.
// The reference model tracks MD busy as an absolute "busy through cycle" index rather than a counter.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       RESET;
  logic [4:0] D_RS_ADDR, D_RT_ADDR, E_WADDR, M_WADDR;
  logic [1:0] D_TUSE_RS, D_TUSE_RT, E_TNEW, M_TNEW;
  logic       D_IS_MD, E_MD_START, E_MD_TYPE;
  logic       STALL_PC, STALL_D, CLEAR_E, MD_BUSY;
  logic       perf_clr;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] STALL_CYCLES;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_until = -100;
  longint perf_model = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk(clk), .RESET(RESET),
    .D_RS_ADDR(D_RS_ADDR), .D_RT_ADDR(D_RT_ADDR),
    .D_TUSE_RS(D_TUSE_RS), .D_TUSE_RT(D_TUSE_RT), .D_IS_MD(D_IS_MD),
    .E_WADDR(E_WADDR), .E_TNEW(E_TNEW), .M_WADDR(M_WADDR), .M_TNEW(M_TNEW),
    .E_MD_START(E_MD_START), .E_MD_TYPE(E_MD_TYPE),
`ifdef STALL_PERF_CNT_EN
    .PERF_CLR(perf_clr), .STALL_CYCLES(STALL_CYCLES),
`endif
    .STALL_PC(STALL_PC), .STALL_D(STALL_D), .CLEAR_E(CLEAR_E), .MD_BUSY(MD_BUSY)
  );

  // An operand must wait if it is needed sooner than any in-flight producer of it delivers.
  function automatic bit needsWait(logic [4:0] a, logic [1:0] tuse);
    if (tuse == 2'd3 || a == 5'd0) return 1'b0;
    if (a == E_WADDR && int'(E_TNEW) > int'(tuse)) return 1'b1;
    if (a == M_WADDR && int'(M_TNEW) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit modelBusy();
    return !RESET && (cyc <= busy_until);
  endfunction

  function automatic bit modelStall();
    if (RESET) return 1'b0;
    return needsWait(D_RS_ADDR, D_TUSE_RS) || needsWait(D_RT_ADDR, D_TUSE_RT) ||
           (D_IS_MD && (modelBusy() || E_MD_START));
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    bit s;
    s = modelStall();
    chk({tag, ".STALL_PC"}, STALL_PC, s);
    chk({tag, ".STALL_D"}, STALL_D, s);
    chk({tag, ".CLEAR_E"}, CLEAR_E, s);
    chk({tag, ".MD_BUSY"}, MD_BUSY, modelBusy());
`ifdef STALL_PERF_CNT_EN
    chk32({tag, ".STALL_CYCLES"}, STALL_CYCLES, 32'(perf_model));
`endif
  endtask

  // Checks the current cycle, then advances the model and the DUT across one rising edge.
  task automatic applyStimulus(input string tag);
    bit s;
    #1;
    checkOutput(tag);
    s = modelStall();
    @(posedge clk);
    if (RESET) busy_until = cyc;
    else if (E_MD_START) busy_until = cyc + (E_MD_TYPE ? 10 : 5);
    if (RESET || perf_clr) perf_model = 0;
    else if (s && perf_model != 64'hFFFF_FFFF) perf_model = perf_model + 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic setIdle();
    RESET = 0; D_RS_ADDR = 0; D_RT_ADDR = 0; D_TUSE_RS = 3; D_TUSE_RT = 3; D_IS_MD = 0;
    E_WADDR = 0; E_TNEW = 0; M_WADDR = 0; M_TNEW = 0; E_MD_START = 0; E_MD_TYPE = 0; perf_clr = 0;
  endtask

  initial begin
    setIdle();
    @(negedge clk);

    // Reset forces every output low even with a hazard and MD request present.
    RESET = 1; D_RS_ADDR = 5; D_TUSE_RS = 0; E_WADDR = 5; E_TNEW = 2; D_IS_MD = 1; E_MD_START = 1;
    applyStimulus("reset0");
    applyStimulus("reset1");
    setIdle();
    applyStimulus("idle");

    // Load-use through E, then through M, then resolved.
    E_WADDR = 5; E_TNEW = 2; D_RS_ADDR = 5; D_TUSE_RS = 1;
    applyStimulus("loaduse_e");
    E_WADDR = 0; E_TNEW = 0; M_WADDR = 5; M_TNEW = 1;
    applyStimulus("loaduse_m");
    M_TNEW = 0;
    applyStimulus("loaduse_done");

    // $0 and unused operands never stall.
    setIdle(); E_WADDR = 0; E_TNEW = 2; D_RT_ADDR = 0; D_TUSE_RT = 0;
    applyStimulus("zero_reg");
    setIdle(); E_WADDR = 5; E_TNEW = 2; D_RS_ADDR = 5; D_TUSE_RS = 3;
    applyStimulus("unused_rs");
    setIdle(); E_WADDR = 7; E_TNEW = 2; D_RT_ADDR = 7; D_TUSE_RT = 1;
    applyStimulus("rt_hazard");

    // Mult with a dependent MD instruction waiting in D throughout.
    setIdle(); D_IS_MD = 1; E_MD_START = 1; E_MD_TYPE = 0;
    applyStimulus("mult_start");
    E_MD_START = 0;
    for (int i = 1; i <= 6; i++) applyStimulus($sformatf("mult_t%0d", i));

    // Div interrupted by reset.
    setIdle(); E_MD_START = 1; E_MD_TYPE = 1;
    applyStimulus("div_start");
    E_MD_START = 0;
    applyStimulus("div_t1");
    applyStimulus("div_t2");
    RESET = 1;
    applyStimulus("div_reset");
    RESET = 0; D_IS_MD = 1;
    applyStimulus("div_after_reset");

    // Div restarted by a mult four cycles later.
    setIdle(); E_MD_START = 1; E_MD_TYPE = 1;
    applyStimulus("restart_div");
    E_MD_START = 0;
    for (int i = 1; i <= 3; i++) applyStimulus($sformatf("restart_t%0d", i));
    E_MD_START = 1; E_MD_TYPE = 0;
    applyStimulus("restart_mult");
    E_MD_START = 0;
    for (int i = 5; i <= 11; i++) applyStimulus($sformatf("restart_t%0d", i));

    // Randomized traffic over a small register window to provoke address matches.
    for (int i = 0; i < 400; i++) begin
      RESET      = ($urandom_range(0, 49) == 0);
      D_RS_ADDR  = 5'($urandom_range(0, 3));
      D_RT_ADDR  = 5'($urandom_range(0, 3));
      D_TUSE_RS  = 2'($urandom_range(0, 3));
      D_TUSE_RT  = 2'($urandom_range(0, 3));
      D_IS_MD    = ($urandom_range(0, 2) == 0);
      E_WADDR    = 5'($urandom_range(0, 3));
      E_TNEW     = 2'($urandom_range(0, 3));
      M_WADDR    = 5'($urandom_range(0, 3));
      M_TNEW     = 2'($urandom_range(0, 3));
      E_MD_START = ($urandom_range(0, 11) == 0);
      E_MD_TYPE  = 1'($urandom_range(0, 1));
`ifdef STALL_PERF_CNT_EN
      perf_clr   = ($urandom_range(0, 29) == 0);
`endif
      applyStimulus("random");
    end

`ifdef STALL_PERF_CNT_EN
    setIdle(); RESET = 1;
    applyStimulus("perf_reset");
    setIdle(); E_WADDR = 5; E_TNEW = 2; D_RS_ADDR = 5; D_TUSE_RS = 1;
    for (int i = 0; i < 7; i++) applyStimulus("perf_stall");
    setIdle();
    #1 chk32("perf_seven", STALL_CYCLES, 32'd7);
    E_WADDR = 5; E_TNEW = 2; D_RS_ADDR = 5; D_TUSE_RS = 1; perf_clr = 1;
    applyStimulus("perf_clr");
    setIdle();
    #1 chk32("perf_cleared", STALL_CYCLES, 32'd0);
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cycles_q;
    perf_model = 64'hFFFF_FFFD;
    E_WADDR = 5; E_TNEW = 2; D_RS_ADDR = 5; D_TUSE_RS = 1;
    for (int i = 0; i < 5; i++) applyStimulus("perf_sat");
    #1 chk32("perf_saturated", STALL_CYCLES, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
